dest_egress_reader: RTL and testbench

- Downstream consumer of the QoS fabric's two destination FIFOs, D0 and D1.
- Pops both FIFOs under fair arbitration and merges words into one registered egress stream with valid/ready handshake.
- Holds a 2-entry output buffer that absorbs the FIFOs' 1-cycle read latency under backpressure.
- Keeps per-destination word counters plus idle/active/error status for the bench and top-level checkers.

---
 rtl/dest_egress_reader.sv | 168 ++++++++++++++++
 tb/tb_dest_egress_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dest_egress_reader.sv
// rtl/dest_egress_reader.sv - merges D0/D1 FIFO pops into one egress stream; define STRICT_PRIO_EN for D0 strict priority
module dest_egress_reader #(
    parameter int BW    = 6,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             D0_empty,
    input  logic             D1_empty,
    input  logic [BW-1:0]    D0_data_out,
    input  logic [BW-1:0]    D1_data_out,
    output logic             D0_rd,
    output logic             D1_rd,
    input  logic             eg_ready,
    output logic             eg_valid,
    output logic [BW-1:0]    eg_data,
    output logic             eg_dest,
    output logic [CNT_W-1:0] cnt_d0,
    output logic [CNT_W-1:0] cnt_d1,
    output logic             idle_out,
    output logic             active_out,
    output logic             error_out
);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t        state;
    logic [1:0]    occ;
    logic [BW-1:0] buf_data [2];
    logic          buf_dest [2];
    logic          inflight;
    logic          inflight_src;
    logic          rr_ptr;

    logic          can_issue;
    logic          pick_d1;
    logic          pop;
    logic          wr_hi;
    logic [BW-1:0] cap_data;

    assign eg_valid = (occ != 2'd0);
    assign eg_data  = buf_data[0];
    assign eg_dest  = buf_dest[0];
    assign pop      = eg_valid & eg_ready;
    assign cap_data = inflight_src ? D1_data_out : D0_data_out;
    // Capture goes behind whatever survives this cycle's pop.
    assign wr_hi    = (occ == 2'd2) || ((occ == 2'd1) && !pop);

    // Read issue: reserve a buffer slot for every word in flight, then arbitrate.
    always_comb begin
        can_issue = !init && ((state == S_IDLE) || (state == S_ACTIVE)) &&
                    (({1'b0, occ} + {2'b00, inflight}) < 3'd2);
        pick_d1 = 1'b0;
`ifdef STRICT_PRIO_EN
        pick_d1 = D0_empty;
`else
        if (!D0_empty && !D1_empty)
            pick_d1 = rr_ptr;
        else
            pick_d1 = D0_empty;
`endif
        D0_rd = can_issue && !pick_d1 && !D0_empty;
        D1_rd = can_issue &&  pick_d1 && !D1_empty;
    end

    // Datapath: in-flight tracking, 2-entry output buffer, counters, error flag, RR pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ          <= 2'd0;
            buf_data[0]  <= '0;
            buf_data[1]  <= '0;
            buf_dest[0]  <= 1'b0;
            buf_dest[1]  <= 1'b0;
            inflight     <= 1'b0;
            inflight_src <= 1'b0;
            rr_ptr       <= 1'b0;
            cnt_d0       <= '0;
            cnt_d1       <= '0;
            error_out    <= 1'b0;
        end else if (init) begin
            occ          <= 2'd0;
            buf_data[0]  <= '0;
            buf_data[1]  <= '0;
            buf_dest[0]  <= 1'b0;
            buf_dest[1]  <= 1'b0;
            inflight     <= 1'b0;
            inflight_src <= 1'b0;
            rr_ptr       <= 1'b0;
            cnt_d0       <= '0;
            cnt_d1       <= '0;
            error_out    <= 1'b0;
        end else begin
            inflight     <= D0_rd | D1_rd;
            inflight_src <= D1_rd;
            // Pointer always ends up on the destination not just served.
            if (D0_rd | D1_rd)
                rr_ptr <= D0_rd;
            if (pop) begin
                buf_data[0] <= buf_data[1];
                buf_dest[0] <= buf_dest[1];
                if (buf_dest[0])
                    cnt_d1 <= cnt_d1 + CNT_ONE;
                else
                    cnt_d0 <= cnt_d0 + CNT_ONE;
            end
            if (inflight) begin
                if (wr_hi) begin
                    buf_data[1] <= cap_data;
                    buf_dest[1] <= inflight_src;
                end else begin
                    buf_data[0] <= cap_data;
                    buf_dest[0] <= inflight_src;
                end
            end
            occ <= occ - {1'b0, pop} + {1'b0, inflight};
            if ((D0_rd & D0_empty) | (D1_rd & D1_empty))
                error_out <= 1'b1;
        end
    end

    // Control FSM with registered idle/active status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_INIT;
            idle_out   <= 1'b0;
            active_out <= 1'b0;
        end else if (init) begin
            state      <= S_INIT;
            idle_out   <= 1'b0;
            active_out <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    state      <= S_IDLE;
                    idle_out   <= 1'b1;
                    active_out <= 1'b0;
                end
                S_IDLE: begin
                    if (!D0_empty || !D1_empty || (occ != 2'd0)) begin
                        state      <= S_ACTIVE;
                        idle_out   <= 1'b0;
                        active_out <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (D0_empty && D1_empty && (occ == 2'd0) && !inflight) begin
                        state      <= S_IDLE;
                        idle_out   <= 1'b1;
                        active_out <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_INIT;
                    idle_out   <= 1'b0;
                    active_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dest_egress_reader.sv
// tb/tb_dest_egress_reader.sv - directed scoreboard bench for dest_egress_reader
module tb_dest_egress_reader;

    localparam int BW    = 6;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             init;
    logic             D0_empty;
    logic             D1_empty;
    logic [BW-1:0]    D0_data_out = '0;
    logic [BW-1:0]    D1_data_out = '0;
    logic             D0_rd;
    logic             D1_rd;
    logic             eg_ready;
    logic             eg_valid;
    logic [BW-1:0]    eg_data;
    logic             eg_dest;
    logic [CNT_W-1:0] cnt_d0;
    logic [CNT_W-1:0] cnt_d1;
    logic             idle_out;
    logic             active_out;
    logic             error_out;

    dest_egress_reader #(.BW(BW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .init(init),
        .D0_empty(D0_empty), .D1_empty(D1_empty),
        .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
        .D0_rd(D0_rd), .D1_rd(D1_rd),
        .eg_ready(eg_ready), .eg_valid(eg_valid), .eg_data(eg_data), .eg_dest(eg_dest),
        .cnt_d0(cnt_d0), .cnt_d1(cnt_d1),
        .idle_out(idle_out), .active_out(active_out), .error_out(error_out)
    );

    always #5 clk = ~clk;

    // FIFO models: 1-cycle read latency, empty derived from pointers.
    logic [BW-1:0] mem0 [256];
    logic [BW-1:0] mem1 [256];
    int w0 = 0, w1 = 0, r0 = 0, r1 = 0;
    assign D0_empty = (r0 == w0);
    assign D1_empty = (r1 == w1);

    always @(posedge clk) begin
        if (D0_rd) begin
            D0_data_out <= mem0[r0[7:0]];
            r0 <= r0 + 1;
        end
        if (D1_rd) begin
            D1_data_out <= mem1[r1[7:0]];
            r1 <= r1 + 1;
        end
    end

    int n_assert = 0, n_fail = 0;
    int cyc = 0, outstanding = 0, first_rd = -1, first_valid = -1, n_rd0 = 0;
    logic [BW:0] exp_q [$];
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [BW-1:0] wa [16];
    logic [BW-1:0] wb [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        logic issued, acc;
        logic [BW:0] e;
        @(negedge clk);
        issued = D0_rd | D1_rd;
        acc    = eg_valid & eg_ready;
        if (issued) begin
            chk("one_rd", 32'(D0_rd & D1_rd), 32'd0);
            chk("rd_nonempty", 32'((D0_rd & D0_empty) | (D1_rd & D1_empty)), 32'd0);
            chk("rd_room", 32'(outstanding < 2), 32'd1);
            if (first_rd < 0) first_rd = cyc;
        end
        if (D0_rd) n_rd0++;
        if (eg_valid && first_valid < 0) first_valid = cyc;
        if (acc) begin
            chk("eg_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("eg_word", 32'({eg_dest, eg_data}), 32'(e));
            end
        end
        if (init) outstanding = 0;
        else outstanding = outstanding + (issued ? 1 : 0) - (acc ? 1 : 0);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load(input bit dst, input logic [BW-1:0] v);
        if (!dst) begin
            mem0[w0[7:0]] = v;
            w0++;
        end else begin
            mem1[w1[7:0]] = v;
            w1++;
        end
    endtask

    task automatic push_exp(input bit dst, input logic [BW-1:0] v);
        exp_q.push_back({dst, v});
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        init = 1'b0;
        tick();
        first_rd = -1;
        first_valid = -1;
        n_rd0 = 0;
    endtask

    task automatic run_to_idle(input int mode, input string tag);
        bit done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            eg_ready = (mode == 1) ? pat[k % 4] : 1'b1;
            tick();
            done = idle_out && (exp_q.size() == 0) && D0_empty && D1_empty;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        eg_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        init = 1'b0;
        eg_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(eg_valid), 32'd0);
        chk("rst_idle", 32'(idle_out), 32'd0);
        chk("rst_active", 32'(active_out), 32'd0);
        chk("rst_error", 32'(error_out), 32'd0);
        chk("rst_cnt", 32'({cnt_d1, cnt_d0}), 32'd0);
        chk("rst_data", 32'({eg_dest, eg_data}), 32'd0);
        reset = 1'b0;

        // init pulse with both FIFOs empty
        do_init();
        chk("init_idle", 32'(idle_out), 32'd1);
        chk("init_valid", 32'(eg_valid), 32'd0);
        chk("init_cnt", 32'({cnt_d1, cnt_d0}), 32'd0);
        chk("init_rd", 32'({D1_rd, D0_rd}), 32'd0);

        // D0-only stream
        load(0, 6'h21); load(0, 6'h2C); load(0, 6'h21); load(0, 6'h2C);
        push_exp(0, 6'h21); push_exp(0, 6'h2C); push_exp(0, 6'h21); push_exp(0, 6'h2C);
        run_to_idle(0, "t2");
        chk("t2_nrd0", 32'(n_rd0), 32'd4);
        chk("t2_latency", 32'(first_valid - first_rd), 32'd2);
        chk("t2_cnt_d0", 32'(cnt_d0), 32'd4);
        chk("t2_cnt_d1", 32'(cnt_d1), 32'd0);
        chk("t2_idle", 32'(idle_out), 32'd1);

        // both FIFOs, 3 words each
        do_init();
        for (int i = 0; i < 3; i++) begin
            load(0, 6'(8'h01 + i));
            load(1, 6'(8'h31 + i));
        end
`ifdef STRICT_PRIO_EN
        for (int i = 0; i < 3; i++) push_exp(0, 6'(8'h01 + i));
        for (int i = 0; i < 3; i++) push_exp(1, 6'(8'h31 + i));
`else
        for (int i = 0; i < 3; i++) begin
            push_exp(0, 6'(8'h01 + i));
            push_exp(1, 6'(8'h31 + i));
        end
`endif
        run_to_idle(0, "t3");
        chk("t3_cnt_d0", 32'(cnt_d0), 32'd3);
        chk("t3_cnt_d1", 32'(cnt_d1), 32'd3);

        // 16+16 words under 1,0,0,1 backpressure
        do_init();
        for (int i = 0; i < 16; i++) begin
            wa[i] = 6'($urandom_range(0, 63));
            wb[i] = 6'($urandom_range(0, 63));
            load(0, wa[i]);
            load(1, wb[i]);
        end
`ifdef STRICT_PRIO_EN
        for (int i = 0; i < 16; i++) push_exp(0, wa[i]);
        for (int i = 0; i < 16; i++) push_exp(1, wb[i]);
`else
        for (int i = 0; i < 16; i++) begin
            push_exp(0, wa[i]);
            push_exp(1, wb[i]);
        end
`endif
        run_to_idle(1, "t4");
        chk("t4_cnt_d0", 32'(cnt_d0), 32'd16);
        chk("t4_cnt_d1", 32'(cnt_d1), 32'd16);

        // counter wrap: 33 words from D0
        do_init();
        for (int i = 0; i < 33; i++) begin
            load(0, 6'(i));
            push_exp(0, 6'(i));
        end
        run_to_idle(0, "t5");
        chk("t5_cnt_wrap", 32'(cnt_d0), 32'd1);
        chk("t5_cnt_d1", 32'(cnt_d1), 32'd0);

        // init while buffer is full and stalled
        do_init();
        eg_ready = 1'b0;
        load(0, 6'h11); load(0, 6'h12); load(0, 6'h13);
        for (int i = 0; i < 5; i++) tick();
        chk("t6_full_valid", 32'(eg_valid), 32'd1);
        chk("t6_full_head", 32'({eg_dest, eg_data}), 32'h11);
        chk("t6_full_occ", 32'(outstanding), 32'd2);
        init = 1'b1;
        tick();
        init = 1'b0;
        exp_q.delete();
        chk("t6_init_valid", 32'(eg_valid), 32'd0);
        chk("t6_init_state", 32'({active_out, idle_out}), 32'd0);
        chk("t6_init_cnt", 32'({cnt_d1, cnt_d0}), 32'd0);
        tick();
        chk("t6_to_idle", 32'(idle_out), 32'd1);
        push_exp(0, 6'h13);
        run_to_idle(0, "t6");
        chk("t6_cnt_d0", 32'(cnt_d0), 32'd1);
        chk("final_error", 32'(error_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
